// File: rtl/exe_alu_arb.sv
// Two-requester arbiter feeding the single ALU issue register, with owner tracking to writeback.
// Define ALU_ARB_ROUND_ROBIN_EN for alternating grants; default build is fixed priority (req0 first).
package dispatcher_pkg;

  typedef struct packed {
    logic       instruction_valid;
    logic       register_write;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic [3:0] alu_op;
    logic       alu_src_imm;
  } dispatcher_alu_ctrl_t;

  typedef struct packed {
    dispatcher_alu_ctrl_t ctrl;
    logic [4:0]           rd;
    logic [31:0]          rs1_data;
    logic [31:0]          rs2_data;
    logic [31:0]          imm;
    logic [31:0]          pc;
  } dispatcher_alu_inf_t;

  localparam logic [3:0] ALU_OP_ADD = 4'd0;

endpackage

module exe_alu_arb
  import dispatcher_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                req0_valid,
  input  logic                req1_valid,
  input  dispatcher_alu_inf_t req0_inf,
  input  dispatcher_alu_inf_t req1_inf,
  output logic                req0_ready,
  output logic                req1_ready,
  output dispatcher_alu_inf_t alu_inf,
  output logic                alu_owner,
  output logic                wb_owner,
  output logic                wb_owner_valid
);

  logic                grant_p0;
  logic                open_p0;
  logic                accept_p0;
  dispatcher_alu_inf_t sel_inf_p0;
  logic                last_grant;

  dispatcher_alu_inf_t inf_p1;
  logic                vld_p1;
  logic                regw_p1;
  logic                br_p1;
  logic                jal_p1;
  logic                jalr_p1;
  logic                owner_p1;

  logic                owner_p2;
  logic                vld_p2;

  // ---- p0: grant selection and handshake ----
  always_comb begin
    grant_p0 = last_grant;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    if (req0_valid && req1_valid) grant_p0 = ~last_grant;
    else if (req0_valid)          grant_p0 = 1'b0;
    else if (req1_valid)          grant_p0 = 1'b1;
`else
    // With nothing pending the grant parks on the last owner; it is never seen as a ready.
    if (req0_valid)      grant_p0 = 1'b0;
    else if (req1_valid) grant_p0 = 1'b1;
`endif
  end

  assign open_p0    = rst & ~stall & ~flush;
  assign req0_ready = open_p0 & req0_valid & ~grant_p0;
  assign req1_ready = open_p0 & req1_valid & grant_p0;
  assign accept_p0  = req0_ready | req1_ready;
  assign sel_inf_p0 = grant_p0 ? req1_inf : req0_inf;

  // ---- p1: ALU issue register (control flags reset, payload free-running) ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1     <= 1'b0;
      regw_p1    <= 1'b0;
      br_p1      <= 1'b0;
      jal_p1     <= 1'b0;
      jalr_p1    <= 1'b0;
      owner_p1   <= 1'b0;
      last_grant <= 1'b1;
      owner_p2   <= 1'b0;
      vld_p2     <= 1'b0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      regw_p1 <= 1'b0;
      br_p1   <= 1'b0;
      jal_p1  <= 1'b0;
      jalr_p1 <= 1'b0;
      vld_p2  <= 1'b0;
    end else if (!stall) begin
      owner_p2 <= owner_p1;
      vld_p2   <= vld_p1;
      if (accept_p0) begin
        vld_p1     <= sel_inf_p0.ctrl.instruction_valid;
        regw_p1    <= sel_inf_p0.ctrl.register_write;
        br_p1      <= sel_inf_p0.ctrl.branch;
        jal_p1     <= sel_inf_p0.ctrl.jal;
        jalr_p1    <= sel_inf_p0.ctrl.jalr;
        owner_p1   <= grant_p0;
        last_grant <= grant_p0;
      end else begin
        vld_p1  <= 1'b0;
        regw_p1 <= 1'b0;
        br_p1   <= 1'b0;
        jal_p1  <= 1'b0;
        jalr_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept_p0) inf_p1 <= sel_inf_p0;
  end

  always_comb begin
    alu_inf                        = inf_p1;
    alu_inf.ctrl.instruction_valid = vld_p1;
    alu_inf.ctrl.register_write    = regw_p1;
    alu_inf.ctrl.branch            = br_p1;
    alu_inf.ctrl.jal               = jal_p1;
    alu_inf.ctrl.jalr              = jalr_p1;
  end

  // ---- p2: owner aligned with the ALU result register ----
  assign alu_owner      = owner_p1;
  assign wb_owner       = owner_p2;
  assign wb_owner_valid = vld_p2;

endmodule
